// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-addressed DataMemory port.
// Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended data.
module mem_access_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [9:0]  reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    output logic [31:0] respRData,
    output logic        respErr,
    output logic [7:0]  memAddress,
    output logic [31:0] memWriteData,
    output logic        memEnRead,
    output logic        memEnWrite,
    input  logic [31:0] memReadData
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

    state_t      state, next_state;
    logic [9:0]  lat_addr;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic        lat_write;
    logic [31:0] lat_wdata;
    logic [31:0] rd_buf;
    logic        lat_misaligned;
    logic [31:0] lane_data;
    logic [31:0] load_data;
    logic [31:0] merged;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == 2'd3) || (size == 2'd1 && offset[0]) || (size == 2'd2 && offset != 2'd0);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lat_addr     <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_write    <= 1'b0;
            lat_wdata    <= '0;
            rd_buf       <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && reqValid) begin
                lat_addr     <= reqAddr;
                lat_size     <= reqSize;
                lat_unsigned <= reqUnsigned;
                lat_write    <= reqWrite;
                lat_wdata    <= reqWData;
            end
            if (state == CAPTURE)
                rd_buf <= memReadData;
        end
    end

    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (reqValid) begin
                    if (is_misaligned(reqSize, reqAddr[1:0]))
                        next_state = DONE;
                    else if (reqWrite && reqSize == 2'd2)
                        next_state = WRITE;
                    else
                        next_state = READ;
                end
            end
            READ:    next_state = CAPTURE;
            CAPTURE: next_state = lat_write ? WRITE : DONE;
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign lat_misaligned = is_misaligned(lat_size, lat_addr[1:0]);

    // Lane extraction/insertion works on the captured word; everything below is state/latch driven only.
    always_comb begin
        lane_data = rd_buf >> {lat_addr[1:0], 3'b000};
        merged    = rd_buf;
        load_data = rd_buf;
        unique case (lat_size)
            2'd0: begin
                merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
                load_data = {{24{~lat_unsigned & lane_data[7]}}, lane_data[7:0]};
            end
            2'd1: begin
                merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
                load_data = {{16{~lat_unsigned & lane_data[15]}}, lane_data[15:0]};
            end
            default: begin
                merged    = lat_wdata;
                load_data = rd_buf;
            end
        endcase
    end

    assign reqReady     = (state == IDLE) && !reset;
    assign respValid    = (state == DONE);
    assign respErr      = (state == DONE) && lat_misaligned;
    assign respRData    = (state == DONE && !lat_write && !lat_misaligned) ? load_data : 32'h0;
    assign memEnRead    = (state == READ) || (state == CAPTURE);
    assign memEnWrite   = (state == WRITE);
    assign memAddress   = (memEnRead || memEnWrite) ? lat_addr[9:2] : 8'h00;
    assign memWriteData = memEnWrite ? merged : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level reference model,
// per-cycle compare process, directed scenarios plus randomized traffic.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [9:0]  reqAddr;
    logic [31:0] reqWData;
    logic        respValid;
    logic [31:0] respRData;
    logic        respErr;
    logic [7:0]  memAddress;
    logic [31:0] memWriteData;
    logic        memEnRead;
    logic        memEnWrite;
    logic [31:0] memReadData;

    mem_access_unit dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr),
        .reqWData(reqWData),
        .respValid(respValid), .respRData(respRData), .respErr(respErr),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memEnRead(memEnRead), .memEnWrite(memEnWrite), .memReadData(memReadData)
    );

    always #5 clock = ~clock;

    // DataMemory: synchronous read and write on the rising edge.
    logic [31:0] mem [256];
    always @(posedge clock) begin
        if (memEnWrite) mem[memAddress] <= memWriteData;
        if (memEnRead)  memReadData <= mem[memAddress];
    end

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [9:0]  addr;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] newword;
    } exp_t;

    logic [31:0] ref_mem [256];
    exp_t        cur;
    int          req_id = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input logic wr, input logic [1:0] size, input logic uns,
                                     input logic [9:0] addr, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] word, sh, mask;
        int          off;
        e.wr      = wr;
        e.size    = size;
        e.addr    = addr;
        e.err     = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        word      = ref_mem[addr[9:2]];
        off       = 8 * int'(addr[1:0]);
        sh        = word >> off;
        e.rdata   = 32'h0;
        e.newword = word;
        if (e.err) begin
            e.lat = 1;
        end else if (!wr) begin
            e.lat = 3;
            if (size == 2'd0)      e.rdata = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            else if (size == 2'd1) e.rdata = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            else                   e.rdata = word;
        end else if (size == 2'd2) begin
            e.lat     = 2;
            e.newword = wdata;
        end else begin
            e.lat     = 4;
            mask      = ((size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << off;
            e.newword = (word & ~mask) | ((wdata << off) & mask);
        end
        return e;
    endfunction

    // Compare process: every cycle, busy or idle, against the expectation of the request in flight.
    initial begin : compare
        int  k;
        int  seen_id;
        bit  active;
        bit  exp_rd, exp_wr;
        seen_id = 0;
        active  = 0;
        k       = 0;
        forever begin
            @(posedge clock);
            if (!reset && req_id != seen_id) begin
                seen_id = req_id;
                active  = 1;
                k       = 0;
            end
            @(negedge clock);
            if (reset) begin
                active = 0;
            end else if (active) begin
                k++;
                exp_rd = !cur.err && !(cur.wr && cur.size == 2'd2) && (k == 1 || k == 2);
                exp_wr = cur.wr && !cur.err && (k == cur.lat - 1);
                check("reqReady_busy", 32'(reqReady), 32'd0);
                check("respValid",     32'(respValid), 32'(k == cur.lat));
                check("memEnRead",     32'(memEnRead), 32'(exp_rd));
                check("memEnWrite",    32'(memEnWrite), 32'(exp_wr));
                check("memAddress",    32'(memAddress), (exp_rd || exp_wr) ? 32'(cur.addr[9:2]) : 32'd0);
                check("memWriteData",  memWriteData, exp_wr ? cur.newword : 32'd0);
                if (k == cur.lat) begin
                    check("respRData", respRData, cur.rdata);
                    check("respErr",   32'(respErr), 32'(cur.err));
                    active = 0;
                end
            end else begin
                check("reqReady_idle",  32'(reqReady), 32'd1);
                check("respValid_idle", 32'(respValid), 32'd0);
                check("mem_idle",       {30'd0, memEnRead, memEnWrite}, 32'd0);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wdata, input bit hold,
                          output logic [31:0] rdata, output logic err);
        exp_t e;
        @(negedge clock);
        e = predict(wr, size, uns, addr, wdata);
        if (wr && !e.err) ref_mem[addr[9:2]] = e.newword;
        cur = e;
        req_id++;
        reqValid    = 1'b1;
        reqWrite    = wr;
        reqSize     = size;
        reqUnsigned = uns;
        reqAddr     = addr;
        reqWData    = wdata;
        @(posedge clock);
        #1;
        // Garbage on the request bus while busy must be ignored.
        reqValid    = hold;
        reqWrite    = 1'($urandom);
        reqSize     = 2'($urandom);
        reqUnsigned = 1'($urandom);
        reqAddr     = 10'($urandom);
        reqWData    = $urandom;
        repeat (e.lat) @(negedge clock);
        rdata = respRData;
        err   = respErr;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            reqValid = 1'b0;
        end
    endtask

    task automatic reset_in_write();
        exp_t e;
        @(negedge clock);
        e = predict(1'b1, 2'd2, 1'b0, 10'h01C, 32'h5555_5555);
        cur = e;
        req_id++;
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd2; reqUnsigned = 1'b0;
        reqAddr  = 10'h01C; reqWData = 32'h5555_5555;
        @(posedge clock);
        reqValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_memEnWrite",   32'(memEnWrite), 32'd0);
        check("rst_memEnRead",    32'(memEnRead), 32'd0);
        check("rst_memAddress",   32'(memAddress), 32'd0);
        check("rst_memWriteData", memWriteData, 32'd0);
        check("rst_reqReady",     32'(reqReady), 32'd0);
        check("rst_respValid",    32'(respValid), 32'd0);
        @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        check("rst_word7_kept", mem[7], 32'hDEAD_BEEF);
    endtask

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        reset = 1'b1;
        reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0;
        reqAddr = '0; reqWData = '0;
        #3;
        check("reset_reqReady",     32'(reqReady), 32'd0);
        check("reset_respValid",    32'(respValid), 32'd0);
        check("reset_respRData",    respRData, 32'd0);
        check("reset_respErr",      32'(respErr), 32'd0);
        check("reset_memEn",        {30'd0, memEnRead, memEnWrite}, 32'd0);
        check("reset_memAddress",   32'(memAddress), 32'd0);
        check("reset_memWriteData", memWriteData, 32'd0);
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 16; i++)
            do_req(1'b1, 2'd2, 1'b0, 10'(i * 4), $urandom, 1'($urandom), rd, er);

        do_req(1'b1, 2'd2, 1'b0, 10'h000, 32'hF0FF_FFFF, 1'b0, rd, er);
        do_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0, 1'b0, rd, er);
        check("word_load_0", rd, 32'hF0FF_FFFF);

        do_req(1'b1, 2'd2, 1'b0, 10'h000, 32'h12AB_80FF, 1'b0, rd, er);
        do_req(1'b0, 2'd0, 1'b0, 10'h001, 32'h0, 1'b0, rd, er);
        check("byte_signed", rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 10'h001, 32'h0, 1'b0, rd, er);
        check("byte_unsigned", rd, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b0, 10'h002, 32'h0, 1'b0, rd, er);
        check("half_signed", rd, 32'h0000_12AB);

        do_req(1'b1, 2'd2, 1'b0, 10'h014, 32'h1122_3344, 1'b0, rd, er);
        do_req(1'b1, 2'd0, 1'b0, 10'h016, 32'h0000_00EE, 1'b0, rd, er);
        check("rmw_store_err", 32'(er), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 10'h014, 32'h0, 1'b0, rd, er);
        check("rmw_result", rd, 32'h11EE_3344);

        do_req(1'b0, 2'd1, 1'b0, 10'h003, 32'h0, 1'b0, rd, er);
        check("mis_half_err", 32'(er), 32'd1);
        check("mis_half_data", rd, 32'd0);
        do_req(1'b1, 2'd2, 1'b0, 10'h006, 32'hCAFE_F00D, 1'b0, rd, er);
        check("mis_word_err", 32'(er), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 10'h004, 32'h0, 1'b0, rd, er);
        check("mis_word_unchanged", rd, ref_mem[1]);

        do_req(1'b1, 2'd1, 1'b0, 10'h022, 32'h0000_BEEF, 1'b1, rd, er);
        do_req(1'b0, 2'd1, 1'b1, 10'h022, 32'h0, 1'b1, rd, er);
        check("b2b_half", rd, 32'h0000_BEEF);

        do_req(1'b1, 2'd2, 1'b0, 10'h01C, 32'hDEAD_BEEF, 1'b0, rd, er);
        reset_in_write();
        do_req(1'b0, 2'd2, 1'b0, 10'h01C, 32'h0, 1'b0, rd, er);
        check("after_reset_word7", rd, 32'hDEAD_BEEF);

        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 10'($urandom_range(0, 63)),
                   $urandom, 1'($urandom), rd, er);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);

        for (int i = 0; i < 16; i++)
            check($sformatf("final_word%0d", i), mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
